traffic_countdown_scan: RTL and testbench

//  Traffic-light phase sequencer with two-digit BCD countdown; directly upstream of bcd2led7seg.

---
 rtl/traffic_countdown_scan.sv | 179 +++++++++++++++++
 tb/tb_traffic_countdown_scan.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_countdown_scan.sv
`default_nettype none
// ============================================================================
// Module      : traffic_countdown_scan
// Description : RED->GREEN->YELLOW phase sequencer with a two-digit BCD
//               countdown, time-multiplexed onto one digit bus for a
//               seven-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_countdown_scan #(
    parameter int CLK_FREQ   = 125_000_000,
    parameter int TICK_HZ    = 1,
    parameter int SCAN_FREQ  = 1000,
    parameter int RED_SEC    = 30,
    parameter int GREEN_SEC  = 25,
    parameter int YELLOW_SEC = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       light_red,
    output logic       light_yellow,
    output logic       light_green,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic [3:0] bcd_scan,
    output logic [1:0] digit_sel,
    output logic       phase_done
);

    localparam int c_PRESCALE = CLK_FREQ / TICK_HZ;
    localparam int c_SCAN_DIV = CLK_FREQ / (2 * SCAN_FREQ);
    localparam int c_PRE_W    = (c_PRESCALE > 1) ? $clog2(c_PRESCALE) : 1;
    localparam int c_SCAN_W   = (c_SCAN_DIV > 1) ? $clog2(c_SCAN_DIV) : 1;

    localparam logic [c_PRE_W-1:0]  c_PRE_LAST  = c_PRE_W'(c_PRESCALE - 1);
    localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(c_SCAN_DIV - 1);

    localparam logic [3:0] c_RED_TENS    = 4'(RED_SEC / 10);
    localparam logic [3:0] c_RED_ONES    = 4'(RED_SEC % 10);
    localparam logic [3:0] c_GREEN_TENS  = 4'(GREEN_SEC / 10);
    localparam logic [3:0] c_GREEN_ONES  = 4'(GREEN_SEC % 10);
    localparam logic [3:0] c_YELLOW_TENS = 4'(YELLOW_SEC / 10);
    localparam logic [3:0] c_YELLOW_ONES = 4'(YELLOW_SEC % 10);

    localparam logic [1:0] c_ST_RED    = 2'd0;
    localparam logic [1:0] c_ST_GREEN  = 2'd1;
    localparam logic [1:0] c_ST_YELLOW = 2'd2;

    localparam logic [1:0] c_SEL_ONES = 2'b01;
    localparam logic [1:0] c_SEL_TENS = 2'b10;

    generate
        if (RED_SEC < 1 || RED_SEC > 99 || GREEN_SEC < 1 || GREEN_SEC > 99 ||
            YELLOW_SEC < 1 || YELLOW_SEC > 99) begin : g_bad_sec
            $error("traffic_countdown_scan: phase durations must be 1..99");
        end
        if ((CLK_FREQ % TICK_HZ) != 0 || (CLK_FREQ % (2 * SCAN_FREQ)) != 0) begin : g_bad_div
            $error("traffic_countdown_scan: CLK_FREQ not divisible by TICK_HZ or 2*SCAN_FREQ");
        end
    endgenerate

    logic [c_PRE_W-1:0]  r_pre_cnt;
    logic [c_SCAN_W-1:0] r_scan_cnt;
    logic [1:0]          r_state;
    logic                r_red;
    logic                r_yellow;
    logic                r_green;
    logic [3:0]          r_tens;
    logic [3:0]          r_ones;
    logic                r_phase_done;
    logic [1:0]          r_digit_sel;
    logic [3:0]          r_bcd_scan;

    logic w_tick;
    logic w_scan_toggle;
    logic w_last_second;

    assign w_tick        = enable && (r_pre_cnt == c_PRE_LAST);
    assign w_scan_toggle = (r_scan_cnt == c_SCAN_LAST);
    assign w_last_second = (r_tens == 4'd0) && (r_ones == 4'd1);

    // Prescaler holds its value while disabled so the next tick is not restarted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre_cnt <= '0;
        end else if (enable) begin
            if (w_tick) begin
                r_pre_cnt <= '0;
            end else begin
                r_pre_cnt <= r_pre_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_RED;
            r_red        <= 1'b1;
            r_yellow     <= 1'b0;
            r_green      <= 1'b0;
            r_tens       <= c_RED_TENS;
            r_ones       <= c_RED_ONES;
            r_phase_done <= 1'b0;
        end else begin
            r_phase_done <= 1'b0;
            if (w_tick) begin
                if (w_last_second) begin
                    // Phase ends on the 01 tick so 00 is never displayed
                    r_phase_done <= 1'b1;
                    case (r_state)
                        c_ST_RED: begin
                            r_state  <= c_ST_GREEN;
                            r_red    <= 1'b0;
                            r_yellow <= 1'b0;
                            r_green  <= 1'b1;
                            r_tens   <= c_GREEN_TENS;
                            r_ones   <= c_GREEN_ONES;
                        end
                        c_ST_GREEN: begin
                            r_state  <= c_ST_YELLOW;
                            r_red    <= 1'b0;
                            r_yellow <= 1'b1;
                            r_green  <= 1'b0;
                            r_tens   <= c_YELLOW_TENS;
                            r_ones   <= c_YELLOW_ONES;
                        end
                        default: begin
                            r_state  <= c_ST_RED;
                            r_red    <= 1'b1;
                            r_yellow <= 1'b0;
                            r_green  <= 1'b0;
                            r_tens   <= c_RED_TENS;
                            r_ones   <= c_RED_ONES;
                        end
                    endcase
                end else if (r_ones == 4'd0) begin
                    r_ones <= 4'd9;
                    r_tens <= r_tens - 4'd1;
                end else begin
                    r_ones <= r_ones - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_cnt  <= '0;
            r_digit_sel <= c_SEL_ONES;
        end else if (w_scan_toggle) begin
            r_scan_cnt  <= '0;
            r_digit_sel <= (r_digit_sel == c_SEL_ONES) ? c_SEL_TENS : c_SEL_ONES;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Invalid code 4'hF blanks a leading zero in the downstream decoder
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcd_scan <= c_RED_ONES;
        end else if (r_digit_sel == c_SEL_TENS) begin
            r_bcd_scan <= (r_tens == 4'd0) ? 4'hF : r_tens;
        end else begin
            r_bcd_scan <= r_ones;
        end
    end

    assign light_red    = r_red;
    assign light_yellow = r_yellow;
    assign light_green  = r_green;
    assign bcd_tens     = r_tens;
    assign bcd_ones     = r_ones;
    assign bcd_scan     = r_bcd_scan;
    assign digit_sel    = r_digit_sel;
    assign phase_done   = r_phase_done;

endmodule
`default_nettype wire

// File: tb/tb_traffic_countdown_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_countdown_scan
// Description : Self-checking bench; expected outputs derived from elapsed
//               enabled/total cycle counts since reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_countdown_scan;

    localparam int c_PRE   = 100;
    localparam int c_DIV   = 5;
    localparam int c_CYCLE = 25;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       light_red;
    logic       light_yellow;
    logic       light_green;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic [3:0] bcd_scan;
    logic [1:0] digit_sel;
    logic       phase_done;

    int vectors = 0;
    int miscompares = 0;
    int pulse_cnt = 0;

    int en_n = 0;
    int tot_n = 0;
    logic last_tick = 1'b0;
    int exp_scan = 2;

    traffic_countdown_scan #(
        .CLK_FREQ  (100),
        .TICK_HZ   (1),
        .SCAN_FREQ (10),
        .RED_SEC   (12),
        .GREEN_SEC (10),
        .YELLOW_SEC(3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .light_red   (light_red),
        .light_yellow(light_yellow),
        .light_green (light_green),
        .bcd_tens    (bcd_tens),
        .bcd_ones    (bcd_ones),
        .bcd_scan    (bcd_scan),
        .digit_sel   (digit_sel),
        .phase_done  (phase_done)
    );

    always #5 clk = ~clk;

    // Position within the 25-second RED(12)/GREEN(10)/YELLOW(3) cycle
    function automatic int phase_of(input int en);
        int p;
        p = (en / c_PRE) % c_CYCLE;
        if (p < 12) return 0;
        if (p < 22) return 1;
        return 2;
    endfunction

    function automatic int rem_of(input int en);
        int p;
        p = (en / c_PRE) % c_CYCLE;
        if (p < 12) return 12 - p;
        if (p < 22) return 22 - p;
        return 25 - p;
    endfunction

    function automatic int dsel_of(input int tot);
        return (((tot / c_DIV) % 2) == 0) ? 1 : 2;
    endfunction

    function automatic int scan_of(input int dsel, input int rem);
        if (dsel == 2) return ((rem / 10) == 0) ? 15 : (rem / 10);
        return rem % 10;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            en_n      <= 0;
            tot_n     <= 0;
            last_tick <= 1'b0;
            exp_scan  <= 2;
        end else begin
            tot_n    <= tot_n + 1;
            exp_scan <= scan_of(dsel_of(tot_n), rem_of(en_n));
            if (enable) begin
                en_n      <= en_n + 1;
                last_tick <= ((en_n + 1) % c_PRE) == 0;
            end else begin
                last_tick <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            int ph;
            int rem;
            int p;
            ph  = phase_of(en_n);
            rem = rem_of(en_n);
            p   = (en_n / c_PRE) % c_CYCLE;
            chk("light_red", light_red, ph == 0);
            chk("light_green", light_green, ph == 1);
            chk("light_yellow", light_yellow, ph == 2);
            chk("bcd_tens", bcd_tens, rem / 10);
            chk("bcd_ones", bcd_ones, rem % 10);
            chk("digit_sel", digit_sel, dsel_of(tot_n));
            chk("bcd_scan", bcd_scan, exp_scan);
            chk("phase_done", phase_done, last_tick && (p == 0 || p == 12 || p == 22));
            chk("never_00", (bcd_tens == 4'd0 && bcd_ones == 4'd0), 0);
            if (phase_done === 1'b1) pulse_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b1;
        chk("lit_reset_red", light_red, 1);
        chk("lit_reset_tens", bcd_tens, 1);
        chk("lit_reset_ones", bcd_ones, 2);
        chk("lit_reset_dsel", digit_sel, 2'b01);
        chk("lit_reset_scan", bcd_scan, 2);
        chk("lit_reset_done", phase_done, 0);

        step(100);
        chk("lit_first_tick_tens", bcd_tens, 1);
        chk("lit_first_tick_ones", bcd_ones, 1);

        step(1100);
        chk("lit_green_lamp", light_green, 1);
        chk("lit_green_red_off", light_red, 0);
        chk("lit_green_tens", bcd_tens, 1);
        chk("lit_green_ones", bcd_ones, 0);

        step(100);
        chk("lit_green09_tens", bcd_tens, 0);
        chk("lit_green09_ones", bcd_ones, 9);
        step(1);
        chk("lit_ones_slot_scan", bcd_scan, 9);
        step(5);
        chk("lit_tens_slot_dsel", digit_sel, 2'b10);
        chk("lit_tens_slot_blank", bcd_scan, 4'hF);

        step(1195);
        chk("lit_wrap_red", light_red, 1);
        chk("lit_wrap_tens", bcd_tens, 1);
        chk("lit_wrap_ones", bcd_ones, 2);
        chk("lit_pulse_count", pulse_cnt, 3);

        step(49);
        enable = 1'b0;
        step(250);
        chk("lit_frozen_tens", bcd_tens, 1);
        chk("lit_frozen_ones", bcd_ones, 2);
        enable = 1'b1;
        step(49);
        chk("lit_resume_before", bcd_ones, 2);
        step(1);
        chk("lit_resume_tick", bcd_ones, 1);

        for (int i = 0; i < 25; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                #1;
                chk("lit_rand_reset_red", light_red, 1);
                step(2);
                reset = 1'b0;
            end
            step($urandom_range(1, 150));
        end

        reset = 1'b1;
        step(2);
        reset  = 1'b0;
        enable = 1'b1;
        step(1520);
        chk("lit_g07_green", light_green, 1);
        chk("lit_g07_tens", bcd_tens, 0);
        chk("lit_g07_ones", bcd_ones, 7);
        reset = 1'b1;
        #1;
        chk("lit_async_red", light_red, 1);
        chk("lit_async_green", light_green, 0);
        chk("lit_async_tens", bcd_tens, 1);
        chk("lit_async_ones", bcd_ones, 2);
        chk("lit_async_dsel", digit_sel, 2'b01);
        chk("lit_async_done", phase_done, 0);
        step(2);
        reset = 1'b0;
        step(300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
